// File: rtl/mmio_uart_tx_pkg.sv
// Shared UART definitions: line FSM states, register indices and STATUS bit
// positions. Kept free of transmitter-only details so a receiver can reuse it.
package mmio_uart_tx_pkg;

   // Serial line framing states (shared by transmitter and a future receiver)
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   // Register indices, taken from mem_addr[3:2]
   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;

   // STATUS bit positions
   localparam int STAT_BUSY      = 0;
   localparam int STAT_HOLD_FULL = 1;
   localparam int STAT_OVERRUN   = 2;

   // Number of data bits per frame
   localparam int UART_DATA_BITS = 8;

   // Pack the STATUS word; every bit not named above reads as zero
   function automatic logic [31:0] status_word(input logic busy,
                                               input logic hold_full,
                                               input logic overrun);
      logic [31:0] w;
      w                 = '0;
      w[STAT_BUSY]      = busy;
      w[STAT_HOLD_FULL] = hold_full;
      w[STAT_OVERRUN]   = overrun;
      return w;
   endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Processor memory bus as seen by an MMIO peripheral.
interface mmio_uart_tx_if;
   logic [31:0] mem_addr;
   logic        mem_rstrb;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_rdata;

   // Processor side
   modport master (
      output mem_addr,
      output mem_rstrb,
      output mem_wdata,
      output mem_wmask,
      input  mem_rdata
   );

   // Peripheral side
   modport slave (
      input  mem_addr,
      input  mem_rstrb,
      input  mem_wdata,
      input  mem_wmask,
      output mem_rdata
   );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last count.
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 234
) (
   input  logic clk,
   input  logic resetn,
   input  logic restart,
   output logic tick
);

   localparam int             CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: held at zero while restart is high, wraps after the last count
   always_comb begin
      cnt_d = cnt_q;
      if (restart || (cnt_q == LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Tick comes straight off the register, so it marks the final cycle of a bit
   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS registers, one-byte holding
// register feeding an 8N1 shifter. TXD is driven straight from a flop.
module mmio_uart_tx
   import mmio_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 234,
   parameter int IO_SEL_BIT   = 22
) (
   input  logic          clk,
   input  logic          resetn,
   mmio_uart_tx_if.slave bus,
   output logic          TXD
);

   // ---------------------------------------------------------------
   // Bus decode
   // ---------------------------------------------------------------
   logic       sel;
   logic [1:0] reg_idx;
   logic       rd_en;
   logic       wr_en;
   logic       txdata_wr;
   logic       status_rd;
   logic       unused_bus;

   assign sel       = bus.mem_addr[IO_SEL_BIT];
   assign reg_idx   = bus.mem_addr[3:2];
   assign rd_en     = sel && bus.mem_rstrb;
   assign wr_en     = sel && (bus.mem_wmask != 4'b0000);
   // A data write must actually carry byte lane 0
   assign txdata_wr = wr_en && (reg_idx == REG_TXDATA) && bus.mem_wmask[0];
   assign status_rd = rd_en && (reg_idx == REG_STATUS);

   // Address bits outside the select/index fields and the upper data lanes are ignored
   assign unused_bus = ^{bus.mem_addr, bus.mem_wdata[31:8], bus.mem_wmask[3:1]};

   // ---------------------------------------------------------------
   // State
   // ---------------------------------------------------------------
   uart_state_e state_q,     state_d;
   logic [7:0]  shift_q,     shift_d;
   logic [2:0]  bit_idx_q,   bit_idx_d;
   logic        txd_q,       txd_d;
   logic [7:0]  hold_q,      hold_d;
   logic        hold_full_q, hold_full_d;
   logic        overrun_q,   overrun_d;
   logic [31:0] rdata_q,     rdata_d;

   logic busy;
   logic bit_tick;
   logic timer_restart;
   logic load_shifter;

   assign busy = (state_q != ST_IDLE);

   // The holding register drains either from idle or straight out of the stop
   // bit, which is what makes consecutive frames butt up with no gap.
   assign load_shifter = hold_full_q &&
                         ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_tick));

   // Timer sits at zero while idle so the start bit always gets a full period
   assign timer_restart = (state_q == ST_IDLE);

   uart_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk     (clk),
      .resetn  (resetn),
      .restart (timer_restart),
      .tick    (bit_tick)
   );

   // ---------------------------------------------------------------
   // Bus side: holding register, overrun flag and read data
   // ---------------------------------------------------------------

   // Next bus-side state; a write landing on the same edge as a drain is accepted
   always_comb begin
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      overrun_d   = overrun_q;
      rdata_d     = rdata_q;

      if (load_shifter) begin
         hold_full_d = 1'b0;
      end

      // Read-to-clear comes first so a simultaneous new overrun is not lost
      if (status_rd) begin
         overrun_d = 1'b0;
      end

      if (txdata_wr) begin
         if (!hold_full_q || load_shifter) begin
            hold_d      = bus.mem_wdata[7:0];
            hold_full_d = 1'b1;
         end else begin
            overrun_d   = 1'b1;
         end
      end

      // Reads report the flags as they stood before this edge
      if (rd_en) begin
         if (reg_idx == REG_STATUS) begin
            rdata_d = status_word(busy, hold_full_q, overrun_q);
         end else begin
            rdata_d = '0;
         end
      end
   end

   // Bus-side registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         overrun_q   <= 1'b0;
         rdata_q     <= '0;
      end else begin
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         overrun_q   <= overrun_d;
         rdata_q     <= rdata_d;
      end
   end

   assign bus.mem_rdata = rdata_q;

   // ---------------------------------------------------------------
   // Line side: framing FSM
   // ---------------------------------------------------------------

   // Next line state; TXD is computed one edge ahead so it leaves a flop
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      txd_d     = txd_q;

      unique case (state_q)
         ST_IDLE: begin
            txd_d = 1'b1;
            if (hold_full_q) begin
               shift_d = hold_q;
               state_d = ST_START;
               txd_d   = 1'b0;
            end
         end

         ST_START: begin
            if (bit_tick) begin
               state_d   = ST_DATA;
               bit_idx_d = '0;
               txd_d     = shift_q[0];
            end
         end

         ST_DATA: begin
            if (bit_tick) begin
               if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
                  state_d = ST_STOP;
                  txd_d   = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
                  txd_d     = shift_q[1];
               end
            end
         end

         ST_STOP: begin
            if (bit_tick) begin
               if (hold_full_q) begin
                  shift_d = hold_q;
                  state_d = ST_START;
                  txd_d   = 1'b0;
               end else begin
                  state_d = ST_IDLE;
                  txd_d   = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
         end
      endcase
   end

   // Line-side FSM registers; reset abandons any frame in flight
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         txd_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         txd_q     <= txd_d;
      end
   end

   assign TXD = txd_q;

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 234; clock cycles per UART bit (27 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have parameter IO_SEL_BIT, default 22; mem_addr bit that selects IO space.
REQ-003 SHALL have port clk  input  1  system clock; the block uses one clock only.
REQ-004 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-005 SHALL have port mem_addr  input  32  byte address driven by the processor.
REQ-006 SHALL have port mem_rstrb  input  1  read strobe, one cycle wide.
REQ-007 SHALL have port mem_wdata  input  32  write data.
REQ-008 SHALL have port mem_wmask  input  4  byte write enables; any nonzero value is a write.
REQ-009 SHALL have port mem_rdata  output  32  registered read data.
REQ-010 SHALL have port TXD  output  1  UART serial line; idles high.

Function
REQ-011 SHALL treat the block as selected only when mem_addr[IO_SEL_BIT]=1; register index = mem_addr[3:2]; all other address bits are ignored.
REQ-012 SHALL implement this register map: index 0 = TXDATA (write-only; reads return 0); index 1 = STATUS (read-only; bit0 busy, bit1 hold_full, bit2 overrun, bits[31:3]=0); indices 2-3 read 0 and ignore writes.
REQ-013 SHALL, on a selected read, load mem_rdata on the clk edge where mem_rstrb=1, giving one-cycle read latency; mem_rdata SHALL hold its value when no selected read occurs.
REQ-014 SHALL, on a selected write to TXDATA with mem_wmask[0]=1 and hold_full=0, latch mem_wdata[7:0] into the 1-byte holding register and set hold_full at that edge.
REQ-015 SHALL, on a TXDATA write with hold_full=1, drop the byte, leave the holding register unchanged, and set the sticky overrun bit.
REQ-016 SHALL clear overrun on the edge of a selected STATUS read; the read returns overrun=1 if it was set before that edge.
REQ-017 SHALL implement the FSM IDLE -> START -> DATA -> STOP -> IDLE.
REQ-018 SHALL, in IDLE with hold_full=1, transfer the holding register to the shifter at the next edge, clear hold_full, and enter START.
REQ-019 SHALL stay CLKS_PER_BIT cycles in each bit period, counting with a bit counter 0..CLKS_PER_BIT-1: START drives TXD=0; DATA sends 8 bits LSB first; STOP drives TXD=1 for one bit period.
REQ-020 SHALL give a frame length of exactly 10*CLKS_PER_BIT cycles.
REQ-021 SHALL, at the end of STOP with hold_full=1, go directly to START with the new byte, so no idle gap appears between frames.
REQ-022 SHALL, when a TXDATA write and a hold-to-shifter transfer occur on the same edge, accept the write with no overrun; the transfer takes the old byte.
REQ-023 SHALL drive busy=1 in every state other than IDLE.
REQ-024 SHALL make TXD a register output with no combinational path from the bus inputs.

Reset
REQ-025 SHALL, with resetn=0 at a clk edge, set state=IDLE, TXD=1, all counters=0, hold_full=0, overrun=0, and mem_rdata=0.
REQ-026 SHALL, on a reset in mid-frame, abort the frame and drive TXD=1 from the next edge; the partial frame is not resumed.

Structure
REQ-027 SHALL place the FSM state encodings, the register indices (TXDATA=0, STATUS=1) and the STATUS bit positions in a shared uart package/include that a future receiver also uses.
REQ-028 SHALL use one sub-module, uart_bit_timer (parameter CLKS_PER_BIT; inputs clk, resetn, restart; output tick at the end of each bit period); the FSM and bus logic stay in mmio_uart_tx.

Verification (bench uses CLKS_PER_BIT=4)
REQ-029 SHALL cover: reset, then write 0x55 to TXDATA -> TXD reads 0,1,0,1,0,1,0,1,0,1 with each level held 4 cycles, frame starting one cycle after the write edge, busy=1 for 40 cycles.
REQ-030 SHALL cover: write 0xA3, then write 0x0F during START -> two back-to-back frames totalling 80 cycles with no idle gap, overrun stays 0.
REQ-031 SHALL cover: three writes 0x01, 0x02, 0x03 on consecutive bus writes -> 0x01 and 0x02 are sent, 0x03 is dropped, STATUS reads 0x7 while the second frame is pending, and the next STATUS read returns overrun=0.
REQ-032 SHALL cover: STATUS read with mem_rstrb on edge N -> mem_rdata valid after edge N; an unselected read (mem_addr[22]=0) leaves mem_rdata unchanged.
REQ-033 SHALL cover: resetn=0 for one cycle in the middle of DATA -> TXD=1 and STATUS=0 on the next cycle, and a following write of 0xFF sends a complete, correct frame.
